// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: load-op bit positions,
// register widths and bundle widths between pipeline stages.
package mem_stage_pkg;

    localparam int LD_B  = 5;
    localparam int LD_H  = 4;
    localparam int LD_W  = 3;
    localparam int LD_BU = 2;
    localparam int LD_HU = 1;
    localparam int LL_W  = 0;

    localparam int LOAD_OP_W = 6;
    localparam int GR_W      = 32;
    localparam int GR_ADDR_W = 5;

    localparam int ES_TO_MS_BUS_W =
        32 + LOAD_OP_W + 1 + 1 + GR_ADDR_W + GR_W;
    localparam int MS_TO_WS_BUS_W =
        32 + 1 + GR_ADDR_W + GR_W;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake bundles around the MEM stage.
// es_ms_if: EX -> MEM (valid/allowin + payload); ms_ws_if: MEM -> WB.
interface es_ms_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_stage_pkg::*;

    logic                 es_to_ms_valid;
    logic                 ms_allowin;
    logic [ADDR_W-1:0]    es_pc;
    logic [LOAD_OP_W-1:0] es_load_op;
    logic                 es_mem_req;
    logic                 es_gr_we;
    logic [GR_ADDR_W-1:0] es_dest;
    logic [DATA_W-1:0]    es_alu_result;

    modport master (
        output es_to_ms_valid, es_pc, es_load_op,
        output es_mem_req, es_gr_we, es_dest,
        output es_alu_result,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_load_op,
        input  es_mem_req, es_gr_we, es_dest,
        input  es_alu_result,
        output ms_allowin
    );
endinterface

interface ms_ws_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_stage_pkg::*;

    logic                 ms_to_ws_valid;
    logic                 ws_allowin;
    logic [ADDR_W-1:0]    ms_pc;
    logic                 ms_gr_we;
    logic [GR_ADDR_W-1:0] ms_dest;
    logic [DATA_W-1:0]    ms_final_result;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we,
        output ms_dest, ms_final_result,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we,
        input  ms_dest, ms_final_result,
        output ws_allowin
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// mem_load_align: picks byte/half/word from the read data by address
// offset and extends it; ports load_op_i, off_i, rdata_i, alu_result_i -> result_o.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [LOAD_OP_W-1:0] load_op_i,
    input  logic [1:0]           off_i,
    input  logic [DATA_W-1:0]    rdata_i,
    input  logic [DATA_W-1:0]    alu_result_i,
    output logic [DATA_W-1:0]    result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    // off_i[0] is ignored: misaligned halves trap before MEM.
    assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        unique case (1'b1)
            load_op_i[LD_B]:
                result_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            load_op_i[LD_BU]:
                result_o = {{(DATA_W-8){1'b0}}, byte_sel};
            load_op_i[LD_H]:
                result_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
            load_op_i[LD_HU]:
                result_o = {{(DATA_W-16){1'b0}}, half_sel};
            load_op_i[LD_W],
            load_op_i[LL_W]:
                result_o = rdata_i;
            default:
                result_o = alu_result_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX bundle, holds SRAM data across WB
// stalls, aligns loads, drives WB and a forwarding tap (clk, resetn, es, ws, rdata, flush, fwd).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    es_ms_if.slave               es,
    ms_ws_if.master              ws,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    input  logic                 ms_flush,
    output logic                 ms_fwd_valid,
    output logic [GR_ADDR_W-1:0] ms_fwd_dest,
    output logic [DATA_W-1:0]    ms_fwd_data
);

    logic                 ms_valid_q, ms_valid_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [LOAD_OP_W-1:0] load_op_q, load_op_d;
    logic                 mem_req_q, mem_req_d;
    logic                 gr_we_q, gr_we_d;
    logic [GR_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]    alu_q, alu_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0]    hold_data_q, hold_data_d;

    logic              ms_ready_go;
    logic              ms_allowin;
    logic              capture;
    logic              hold_set;
    logic [DATA_W-1:0] rdata_eff;
    logic [DATA_W-1:0] final_result;

    assign ms_ready_go = 1'b1;
    assign ms_allowin  = !ms_valid_q | (ms_ready_go & ws.ws_allowin);
    assign capture     = es.es_to_ms_valid & ms_allowin & !ms_flush;

    // SRAM data is only live for one cycle; park it if WB stalls.
    assign hold_set = ms_valid_q & mem_req_q & !hold_vld_q
                    & !ws.ws_allowin;

    always_comb begin
        ms_valid_d  = ms_valid_q;
        pc_d        = pc_q;
        load_op_d   = load_op_q;
        mem_req_d   = mem_req_q;
        gr_we_d     = gr_we_q;
        dest_d      = dest_q;
        alu_d       = alu_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;

        if (ms_flush)
            ms_valid_d = 1'b0;
        else if (ms_allowin)
            ms_valid_d = es.es_to_ms_valid;

        if (ms_flush) begin
            hold_vld_d = 1'b0;
        end else if (capture) begin
            pc_d       = es.es_pc;
            load_op_d  = es.es_load_op;
            mem_req_d  = es.es_mem_req;
            gr_we_d    = es.es_gr_we;
            dest_d     = es.es_dest;
            alu_d      = es.es_alu_result;
            hold_vld_d = 1'b0;
        end else if (hold_set) begin
            hold_vld_d  = 1'b1;
            hold_data_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            pc_q        <= '0;
            load_op_q   <= '0;
            mem_req_q   <= 1'b0;
            gr_we_q     <= 1'b0;
            dest_q      <= '0;
            alu_q       <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            pc_q        <= pc_d;
            load_op_q   <= load_op_d;
            mem_req_q   <= mem_req_d;
            gr_we_q     <= gr_we_d;
            dest_q      <= dest_d;
            alu_q       <= alu_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign rdata_eff = hold_vld_q ? hold_data_q : data_sram_rdata;

    mem_load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .load_op_i   (load_op_q),
        .off_i       (alu_q[1:0]),
        .rdata_i     (rdata_eff),
        .alu_result_i(alu_q),
        .result_o    (final_result)
    );

    assign es.ms_allowin        = ms_allowin;
    assign ws.ms_to_ws_valid    = ms_valid_q & ms_ready_go;
    assign ws.ms_pc             = pc_q;
    assign ws.ms_gr_we          = gr_we_q;
    assign ws.ms_dest           = dest_q;
    assign ws.ms_final_result   = final_result;

    assign ms_fwd_valid = ms_valid_q & gr_we_q & (dest_q != '0);
    assign ms_fwd_dest  = dest_q;
    assign ms_fwd_data  = final_result;

    always_ff @(posedge clk) begin
        if (resetn && ms_valid_q)
            assert ($onehot0(load_op_q));
    end

endmodule
